complex_vector_pingpong_mem: RTL and testbench

//  Double-buffered row memory for one complex solver vector (r, rr, x, p or pp).

---
 rtl/complex_vector_pingpong_mem.sv | 133 +++++++++++++
 tb/tb_complex_vector_pingpong_mem.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_vector_pingpong_mem.sv
// Double-buffered complex vector row memory; banks swap at end of iteration.
// Optional conjugate read port enabled by COMPLEX_MEM_CONJ_RD_EN.
module complex_vector_pingpong_mem #(
  parameter int number_of_equations_per_cluster = 10,
  parameter int element_width = 64,
  parameter int no_of_units = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic wr_en,
  input  logic [31:0] wr_addr,
  input  logic [element_width*no_of_units-1:0] wr_data,
  input  logic init_en,
  input  logic [31:0] init_addr,
  input  logic [element_width*no_of_units-1:0] init_data,
  input  logic rd_en,
  input  logic [31:0] rd_addr,
`ifdef COMPLEX_MEM_CONJ_RD_EN
  input  logic rd_conj,
`endif
  input  logic swap,
  output logic [element_width*no_of_units-1:0] rd_data,
  output logic rd_valid,
  output logic bank_sel,
  output logic [31:0] wr_count,
  output logic wr_complete,
  output logic err
);

  localparam int N = number_of_equations_per_cluster;
  localparam int EW = element_width;
  localparam int U = no_of_units;
  localparam int RW = EW * U;
  localparam int ROWS = (N + U - 1) / U;
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LAST_LANES = N - (ROWS - 1) * U;

  function automatic logic [RW-1:0] last_mask();
    logic [RW-1:0] m;
    m = '0;
    for (int k = 0; k < U; k++)
      if (k < LAST_LANES) m[EW*k +: EW] = '1;
    return m;
  endfunction

  localparam logic [RW-1:0] LAST_MASK = last_mask();

  logic [RW-1:0] mem [2][ROWS];
  logic [ROWS-1:0] written;

  logic wr_ok, init_ok, rd_ok;
  logic wr_fire, init_fire, rd_fire;
  logic [AW-1:0] wr_idx, init_idx, rd_idx;
  logic [RW-1:0] wr_row, init_row, rd_row;
  logic new_row;
  logic bad_access;

  assign wr_ok = wr_addr < 32'(ROWS);
  assign init_ok = init_addr < 32'(ROWS);
  assign rd_ok = rd_addr < 32'(ROWS);

  assign wr_fire = wr_en && wr_ok;
  assign init_fire = init_en && init_ok;
  assign rd_fire = rd_en && rd_ok;

  assign wr_idx = wr_addr[AW-1:0];
  assign init_idx = init_addr[AW-1:0];
  assign rd_idx = rd_addr[AW-1:0];

  // padded lanes of the last row are stored as zero so they never enter dot products
  assign wr_row = (wr_idx == AW'(ROWS - 1)) ? (wr_data & LAST_MASK) : wr_data;
  assign init_row = (init_idx == AW'(ROWS - 1)) ? (init_data & LAST_MASK) : init_data;

  assign new_row = wr_fire && !written[wr_idx];

  assign bad_access = (wr_en && !wr_ok) || (init_en && !init_ok) ||
                      (rd_en && !rd_ok) || (swap && !wr_complete);

  assign wr_complete = (wr_count == 32'(ROWS));

`ifdef COMPLEX_MEM_CONJ_RD_EN
  function automatic logic [RW-1:0] conj_mask();
    logic [RW-1:0] m;
    m = '0;
    for (int k = 0; k < U; k++) m[EW*k + 31] = 1'b1;
    return m;
  endfunction

  localparam logic [RW-1:0] CONJ_MASK = conj_mask();

  assign rd_row = mem[bank_sel][rd_idx] ^ (rd_conj ? CONJ_MASK : '0);
`else
  assign rd_row = mem[bank_sel][rd_idx];
`endif

  // write and init always hit opposite banks, so both may land in one cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wr_fire) mem[~bank_sel][wr_idx] <= wr_row;
      if (init_fire) mem[bank_sel][init_idx] <= init_row;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_sel <= 1'b0;
      written <= '0;
      wr_count <= '0;
      err <= 1'b0;
    end else begin
      if (swap) begin
        bank_sel <= ~bank_sel;
        written <= '0;
        wr_count <= '0;
      end else if (new_row) begin
        written[wr_idx] <= 1'b1;
        wr_count <= wr_count + 32'd1;
      end
      if (bad_access) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) rd_data <= rd_row;
    end
  end

endmodule

// File: tb/tb_complex_vector_pingpong_mem.sv
// Directed bench for complex_vector_pingpong_mem.
// Conjugate read checks run when COMPLEX_MEM_CONJ_RD_EN is defined.
module tb_complex_vector_pingpong_mem;

  localparam int RW = 512;

  logic clk = 1'b0;
  logic reset;
  logic wr_en;
  logic [31:0] wr_addr;
  logic [RW-1:0] wr_data;
  logic init_en;
  logic [31:0] init_addr;
  logic [RW-1:0] init_data;
  logic rd_en;
  logic [31:0] rd_addr;
  logic rd_conj;
  logic swap;
  logic [RW-1:0] rd_data;
  logic rd_valid;
  logic bank_sel;
  logic [31:0] wr_count;
  logic wr_complete;
  logic err;

  int total = 0;
  int bad = 0;

  localparam logic [63:0] V = 64'h3F800000_40000000;
  localparam logic [63:0] A = 64'hAAAAAAAA_AAAAAAAA;
  localparam logic [63:0] B = 64'h01234567_89ABCDEF;
  localparam logic [63:0] C = 64'h11112222_33334444;
  localparam logic [63:0] D = 64'hDDDD0000_DDDD0000;
  localparam logic [63:0] E = 64'hEEEE1111_EEEE1111;
  localparam logic [63:0] P = 64'h3F800000_3F800000;
  localparam logic [63:0] Q = 64'h3F800000_BF800000;

  always #5 clk = ~clk;

  complex_vector_pingpong_mem dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .init_en(init_en),
    .init_addr(init_addr),
    .init_data(init_data),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
`ifdef COMPLEX_MEM_CONJ_RD_EN
    .rd_conj(rd_conj),
`endif
    .swap(swap),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .bank_sel(bank_sel),
    .wr_count(wr_count),
    .wr_complete(wr_complete),
    .err(err)
  );

  function automatic logic [RW-1:0] full(input logic [63:0] v);
    return {8{v}};
  endfunction

  function automatic logic [RW-1:0] last(input logic [63:0] v);
    return {384'h0, v, v};
  endfunction

  task automatic chk(input string tag, input logic [RW-1:0] got,
                     input logic [RW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    init_en = 1'b0;
    init_addr = '0;
    init_data = '0;
    rd_en = 1'b0;
    rd_addr = '0;
    rd_conj = 1'b0;
    swap = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
  endtask

  task automatic wr(input int a, input logic [63:0] v);
    wr_en = 1'b1;
    wr_addr = 32'(a);
    wr_data = full(v);
    tick();
  endtask

  task automatic init(input int a, input logic [63:0] v);
    init_en = 1'b1;
    init_addr = 32'(a);
    init_data = full(v);
    tick();
  endtask

  task automatic rd(input int a);
    rd_en = 1'b1;
    rd_addr = 32'(a);
    tick();
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    do_reset();
    chk("rst_bank", RW'(bank_sel), RW'(0));
    chk("rst_rdv", RW'(rd_valid), RW'(0));
    chk("rst_rdd", rd_data, '0);
    chk("rst_cnt", RW'(wr_count), RW'(0));
    chk("rst_cmp", RW'(wr_complete), RW'(0));
    chk("rst_err", RW'(err), RW'(0));

    init(0, V);
    init(1, V);
    rd(1);
    chk("t1_rdv", RW'(rd_valid), RW'(1));
    chk("t1_row1", rd_data, last(V));
    rd(0);
    chk("t1_row0", rd_data, full(V));
    tick();
    chk("t1_idle_rdv", RW'(rd_valid), RW'(0));
    chk("t1_hold", rd_data, full(V));

    wr(0, A);
    chk("t2_cnt1", RW'(wr_count), RW'(1));
    chk("t2_cmp0", RW'(wr_complete), RW'(0));
    wr(1, A);
    chk("t2_cnt2", RW'(wr_count), RW'(2));
    chk("t2_cmp1", RW'(wr_complete), RW'(1));
    do_swap();
    chk("t2_bank", RW'(bank_sel), RW'(1));
    chk("t2_cnt0", RW'(wr_count), RW'(0));
    chk("t2_err", RW'(err), RW'(0));
    rd(0);
    chk("t2_row0", rd_data, full(A));
    rd(1);
    chk("t2_row1", rd_data, last(A));

    wr(0, C);
    wr(0, B);
    chk("t3_rewrite_cnt", RW'(wr_count), RW'(1));
    do_swap();
    chk("t3_bank", RW'(bank_sel), RW'(0));
    chk("t3_err", RW'(err), RW'(1));
    rd(0);
    chk("t3_row0", rd_data, full(B));
    tick();
    chk("t3_err_sticky", RW'(err), RW'(1));

    wr_en = 1'b1;
    wr_addr = 32'd1;
    wr_data = full(C);
    swap = 1'b1;
    rd_en = 1'b1;
    rd_addr = 32'd1;
    tick();
    chk("t4_old_row", rd_data, last(V));
    chk("t4_bank", RW'(bank_sel), RW'(1));
    chk("t4_cnt", RW'(wr_count), RW'(0));
    rd(1);
    chk("t4_new_row", rd_data, last(C));

    do_reset();
    chk("t5_rst_bank", RW'(bank_sel), RW'(0));
    chk("t5_rst_err", RW'(err), RW'(0));
    rd(0);
    chk("t5_row0", rd_data, full(B));
    rd(5);
    chk("t5_oor_rdv", RW'(rd_valid), RW'(0));
    chk("t5_oor_hold", rd_data, full(B));
    chk("t5_oor_err", RW'(err), RW'(1));
    do_reset();
    chk("t5_err_clr", RW'(err), RW'(0));
    wr(2, E);
    chk("t5_wr_oor_err", RW'(err), RW'(1));
    chk("t5_wr_oor_cnt", RW'(wr_count), RW'(0));
    do_reset();
    init(3, E);
    chk("t5_init_oor_err", RW'(err), RW'(1));
    do_reset();

    init_en = 1'b1;
    init_addr = 32'd0;
    init_data = full(D);
    wr_en = 1'b1;
    wr_addr = 32'd0;
    wr_data = full(E);
    tick();
    chk("both_cnt", RW'(wr_count), RW'(1));
    rd(0);
    chk("both_init", rd_data, full(D));
    wr(1, E);
    do_swap();
    chk("both_err", RW'(err), RW'(0));
    rd(0);
    chk("both_wr", rd_data, full(E));

`ifdef COMPLEX_MEM_CONJ_RD_EN
    init(0, P);
    rd_en = 1'b1;
    rd_addr = 32'd0;
    rd_conj = 1'b1;
    tick();
    chk("t6_conj", rd_data, full(Q));
    rd(0);
    chk("t6_raw", rd_data, full(P));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
